// File: rtl/pdh_frame_capture.sv
// PDH DMA capture stage: decimates the core's sample word into a small FIFO and
// streams exactly FRAME_LEN beats on AXI4-Stream, then signals frame completion.
module pdh_frame_capture #(
  parameter int DATA_WIDTH  = 64,
  parameter int FRAME_LEN   = 1024,
  parameter int FIFO_DEPTH  = 16,
  parameter int DECIM_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  input  logic [DECIM_WIDTH-1:0]           decim_i,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             finished_o,
  output logic                             overflow_o,
  output logic [$clog2(FRAME_LEN+1)-1:0]   sample_count_o
);
  localparam int CW = $clog2(FRAME_LEN+1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_e;

  state_e                 state_q;
  logic [DECIM_WIDTH-1:0] decim_q, dcnt_q;
  logic [CW-1:0]          sample_cnt_q, beat_cnt_q;
  logic [PW-1:0]          wptr_q, wvis_q, rptr_q;
  logic                   overflow_q, finished_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic [PW-1:0] occ;
  logic          full, valid, hs, strobe, wr_en, last_beat, last_hs;

  // Occupancy uses the true write pointer; the stream side only sees a write one
  // cycle later (wvis_q), so tvalid comes straight from registers.
  assign occ       = wptr_q - rptr_q;
  assign full      = (occ == PW'(FIFO_DEPTH));
  assign valid     = (rptr_q != wvis_q);
  assign hs        = valid && m_axis_tready;
  assign strobe    = (state_q == S_CAPTURE) && (dcnt_q == '0);
  assign wr_en     = strobe && (!full || hs);
  assign last_beat = (beat_cnt_q == CW'(FRAME_LEN-1));
  assign last_hs   = hs && last_beat;

  assign m_axis_tvalid  = valid;
  assign m_axis_tdata   = valid ? mem_q[rptr_q[AW-1:0]] : '0;
  assign m_axis_tlast   = valid && last_beat;
  assign finished_o     = finished_q;
  assign overflow_o     = overflow_q;
  assign sample_count_o = sample_cnt_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      decim_q      <= '0;
      dcnt_q       <= '0;
      sample_cnt_q <= '0;
      beat_cnt_q   <= '0;
      wptr_q       <= '0;
      wvis_q       <= '0;
      rptr_q       <= '0;
      overflow_q   <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      wvis_q <= wptr_q;
      if (hs) begin
        rptr_q     <= rptr_q + PW'(1);
        beat_cnt_q <= beat_cnt_q + CW'(1);
      end
      if (wr_en) begin
        wptr_q       <= wptr_q + PW'(1);
        sample_cnt_q <= sample_cnt_q + CW'(1);
      end
      if (strobe && !wr_en) overflow_q <= 1'b1;

      case (state_q)
        S_IDLE: if (enable_i) begin
          state_q      <= S_CAPTURE;
          decim_q      <= decim_i;
          dcnt_q       <= '0;
          sample_cnt_q <= '0;
          beat_cnt_q   <= '0;
          overflow_q   <= 1'b0;
          wptr_q       <= '0;
          wvis_q       <= '0;
          rptr_q       <= '0;
        end
        S_CAPTURE: begin
          dcnt_q <= (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_WIDTH'(1);
          if (last_hs) begin
            state_q    <= S_DONE;
            finished_q <= 1'b1;
          end else if (wr_en && sample_cnt_q == CW'(FRAME_LEN-1)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: if (last_hs) begin
          state_q    <= S_DONE;
          finished_q <= 1'b1;
        end
        // Enable must drop before another frame can start.
        S_DONE: if (!enable_i) begin
          state_q    <= S_IDLE;
          finished_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pdh_frame_capture.sv
// Randomised bench for pdh_frame_capture: a queue-based frame model predicts every
// beat, count and flag cycle by cycle.
module tb_pdh_frame_capture;
  localparam int DW  = 64;
  localparam int FL  = 8;
  localparam int FD  = 4;
  localparam int DCW = 16;
  localparam int CW  = $clog2(FL+1);

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic           enable_i = 1'b0;
  logic           tready = 1'b0;
  logic [DW-1:0]  data_i = '0;
  logic [DCW-1:0] decim_i = '0;
  logic [DW-1:0]  tdata;
  logic           tvalid, tlast, finished, overflow;
  logic [CW-1:0]  scnt;
  logic [63:0]    cyc = '0;

  int checks = 0;
  int passes = 0;
  logic [DW-1:0] beats[$];

  pdh_frame_capture #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD), .DECIM_WIDTH(DCW)) dut (
    .clk(clk), .rst_i(rst_i), .enable_i(enable_i), .data_i(data_i), .decim_i(decim_i),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .finished_o(finished), .overflow_o(overflow), .sample_count_o(scnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;

  // mode: 0 = ready always, 1 = ready low for first 10 capture cycles, 2 = random ready.
  // A sample written at the end of cycle w is offered on the stream from cycle w+2.
  task automatic run_frame(input int d, input int mode, input int drop_after, input int abort_at);
    logic [DW-1:0] qv[$];
    int qw[$];
    int k, acc, nb, done_k;
    bit ovf, exp_v, exp_l, hs, prev_stall;
    logic [DW-1:0] exp_d, prev_d;
    k = 0; acc = 0; nb = 0; done_k = -1; ovf = 0; prev_stall = 0; prev_d = '0;
    beats.delete();
    @(negedge clk);
    enable_i = 1'b1; decim_i = DCW'(d); tready = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      data_i = cyc;
      if (k == 3) decim_i = DCW'(d + 5);
      case (mode)
        0:       tready = 1'b1;
        1:       tready = (k >= 10);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      if (k == abort_at) begin
        rst_i = 1'b1;
        #1;
        checks++;
        if ({tvalid, tlast, finished, overflow} !== 4'b0 || scnt !== '0 || tdata !== '0)
          $display("FAIL abort_reset got v=%b l=%b f=%b o=%b cnt=%0d d=%h expected all zero",
                   tvalid, tlast, finished, overflow, scnt, tdata);
        else passes++;
        @(negedge clk);
        rst_i = 1'b0; enable_i = 1'b0;
        return;
      end
      exp_v = (qv.size() > 0) && (qw[0] <= k - 2);
      exp_d = exp_v ? qv[0] : '0;
      exp_l = exp_v && (nb == FL - 1);
      checks++;
      if (tvalid !== exp_v) $display("FAIL tvalid k=%0d got %b expected %b", k, tvalid, exp_v);
      else passes++;
      if (exp_v) begin
        checks++;
        if (tdata !== exp_d) $display("FAIL tdata k=%0d got %h expected %h", k, tdata, exp_d);
        else passes++;
      end
      checks++;
      if (tlast !== exp_l) $display("FAIL tlast k=%0d got %b expected %b", k, tlast, exp_l);
      else passes++;
      checks++;
      if (scnt !== CW'(acc)) $display("FAIL sample_count k=%0d got %0d expected %0d", k, scnt, acc);
      else passes++;
      checks++;
      if (overflow !== ovf) $display("FAIL overflow k=%0d got %b expected %b", k, overflow, ovf);
      else passes++;
      checks++;
      if (finished !== 1'b0) $display("FAIL finished_early k=%0d got %b expected 0", k, finished);
      else passes++;
      if (prev_stall) begin
        checks++;
        if (tdata !== prev_d) $display("FAIL stall_hold k=%0d got %h expected %h", k, tdata, prev_d);
        else passes++;
      end
      hs = exp_v && tready;
      prev_stall = exp_v && !tready;
      prev_d = tdata;
      if (acc < FL && (k % (d + 1)) == 0) begin
        if (qv.size() < FD || hs) begin
          qv.push_back(data_i); qw.push_back(k); acc++;
        end else ovf = 1'b1;
      end
      if (hs) begin
        beats.push_back(qv.pop_front());
        void'(qw.pop_front());
        nb++;
        if (nb == FL) done_k = k;
      end
      if (drop_after >= 0 && nb >= drop_after) enable_i = 1'b0;
      @(posedge clk);
      k++;
      if (done_k >= 0) break;
      if (k > 400) begin
        checks++;
        $display("FAIL frame_timeout beats got %0d expected %0d", nb, FL);
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (finished !== 1'b1 || tvalid !== 1'b0)
      $display("FAIL finished_rise got f=%b v=%b expected f=1 v=0", finished, tvalid);
    else passes++;
    checks++;
    if (beats.size() != FL) $display("FAIL beat_total got %0d expected %0d", beats.size(), FL);
    else passes++;
    if (enable_i) begin
      repeat (4) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if (finished !== 1'b1 || tvalid !== 1'b0 || scnt !== CW'(FL))
          $display("FAIL no_rearm got f=%b v=%b cnt=%0d expected f=1 v=0 cnt=%0d",
                   finished, tvalid, scnt, FL);
        else passes++;
      end
    end
    enable_i = 1'b0;
    @(negedge clk);
    checks++;
    if (finished !== 1'b0) $display("FAIL finished_fall got %b expected 0", finished);
    else passes++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({tvalid, tlast, finished, overflow} !== 4'b0 || scnt !== '0 || tdata !== '0)
      $display("FAIL reset_state got v=%b l=%b f=%b o=%b cnt=%0d d=%h expected all zero",
               tvalid, tlast, finished, overflow, scnt, tdata);
    else passes++;
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(0, 0, -1, -1);
    for (int i = 1; i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== beats[0] + DW'(i))
        $display("FAIL basic_seq beat %0d got %h expected %h", i, beats[i], beats[0] + DW'(i));
      else passes++;
    end
    checks++;
    if (overflow !== 1'b0) $display("FAIL basic_overflow got %b expected 0", overflow);
    else passes++;
  endtask

  task automatic test_decimation();
    run_frame(3, 0, -1, -1);
    for (int i = 1; i < beats.size(); i++) begin
      checks++;
      if (beats[i] - beats[i-1] !== DW'(4))
        $display("FAIL decim_spacing beat %0d got %0d expected 4", i, beats[i] - beats[i-1]);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    run_frame(0, 1, -1, -1);
    checks++;
    if (beats.size() != FL) $display("FAIL ovf_beats got %0d expected %0d", beats.size(), FL);
    else begin
      if (beats[3] - beats[0] !== DW'(3) || beats[4] - beats[3] !== DW'(7) || beats[7] - beats[4] !== DW'(3))
        $display("FAIL ovf_gap got %0d/%0d/%0d expected 3/7/3",
                 beats[3] - beats[0], beats[4] - beats[3], beats[7] - beats[4]);
      else passes++;
    end
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b expected 1", overflow);
    else passes++;
  endtask

  task automatic test_stall_random();
    repeat (4) run_frame($urandom_range(0, 2), 2, -1, -1);
  endtask

  task automatic test_enable_drop();
    run_frame(0, 0, 3, -1);
    run_frame(1, 2, 3, -1);
  endtask

  task automatic test_reset_mid();
    run_frame(0, 0, -1, 8);
    checks++;
    if (tvalid !== 1'b0 || scnt !== '0) $display("FAIL post_reset got v=%b cnt=%0d expected 0/0", tvalid, scnt);
    else passes++;
    run_frame(1, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decimation();
    test_overflow();
    test_stall_random();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pdh_frame_capture.md
# pdh_frame_capture

Downstream DMA capture stage for the PDH core. When the core's frame command raises `enable_i`, this block samples the core's 64-bit `{i_feed, q_feed, cos_theta, sin_theta}` word at a programmable decimation rate. It buffers the samples in a small FIFO and emits exactly `FRAME_LEN` beats on an AXI4-Stream master to the DMA engine, asserting `tlast` on the final beat. Once the frame has fully drained, it reports completion on `finished_o`, which feeds the core's `dma_finished_i`.

## Interface
- `DATA_WIDTH`, 64, sample and stream width
- `FRAME_LEN`, 1024, beats per frame, ≥2
- `FIFO_DEPTH`, 16, buffer entries, power of 2, ≥4
- `DECIM_WIDTH`, 16, width of the decimation control
- `clk`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `enable_i`  in  1  frame request level, from core `dma_enable_o`
- `data_i`  in  DATA_WIDTH  sample word, from core `dma_data_o`
- `decim_i`  in  DECIM_WIDTH  sample period minus 1; latched at frame start
- `m_axis_tdata`  out  DATA_WIDTH  stream data
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready
- `m_axis_tlast`  out  1  final beat of frame
- `finished_o`  out  1  frame complete; to core `dma_finished_i`
- `overflow_o`  out  1  sticky: at least one sample dropped this frame
- `sample_count_o`  out  $clog2(FRAME_LEN+1)  samples written this frame

## Operation
- **States:** IDLE, CAPTURE, DRAIN, DONE.
- **IDLE:**
  - `enable_i`=1 → CAPTURE.
  - On that transition: latch `decim_i` into `decim_r`; clear the decimation counter, `sample_count`, output beat count and `overflow_o`; flush the FIFO.
- **CAPTURE:**
  - Decimation counter runs 0..`decim_r`, then wraps to 0.
  - A sample strobe occurs when the counter is 0.
  - The first strobe is the first CAPTURE cycle.
- **Write on strobe:**
  - Accepted if FIFO occupancy < `FIFO_DEPTH`, or if a stream handshake occurs the same cycle (simultaneous read and write at full is allowed).
  - Otherwise the sample is dropped, `overflow_o` ← 1, and `sample_count` is not incremented.
- **Leaving CAPTURE:** when an accepted write brings `sample_count` to `FRAME_LEN`, go to DRAIN. No further writes occur.
- **DRAIN:**
  - When the handshake on beat `FRAME_LEN`-1 (0-based beat count) completes, go to DONE.
  - This can already occur in CAPTURE if the FIFO empties on the same cycle as the last write. In that case go directly to DONE.
- **DONE:**
  - `finished_o`=1.
  - `enable_i`=0 → IDLE. `finished_o` clears on entering IDLE.
  - `enable_i` held high keeps the block in DONE; there is no auto re-arm.
- **Stream:**
  - `tvalid` = FIFO not empty (first-word fall-through); `tdata` = FIFO head.
  - Handshake = `tvalid` & `tready`.
  - `tlast` = `tvalid` & (beat count == `FRAME_LEN`-1).
  - While `tvalid`=1 and `tready`=0, `tdata`/`tvalid`/`tlast` hold stable.
- **`enable_i` deassert in CAPTURE or DRAIN:** ignored; the frame always completes, for AXIS protocol safety. Only `rst_i` aborts a frame.
- **Arithmetic:**
  - All counters are unsigned.
  - Beat count and `sample_count` never exceed `FRAME_LEN`.
  - Decimation compare is against `decim_r`, not the live `decim_i`.

## Timing
- **Reset values:** state IDLE; `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `finished_o`=0, `overflow_o`=0, `sample_count_o`=0; FIFO empty.
- **Reset mid-frame:** all of the above apply immediately (asynchronous); FIFO contents are discarded.
- **Start latency:** `enable_i` sampled high at edge N → first sample is `data_i` at edge N+1 → `tvalid` high after edge N+2.
- **Write-to-output latency:** 1 cycle into an empty FIFO.
- **Decimation `decim_r`=D:** strobes every D+1 cycles; D=0 gives every cycle.
- **`finished_o`:** rises the cycle after the last-beat handshake. Falls the cycle after `enable_i` is sampled low in DONE.
- **`sample_count_o`:** registered; updates the cycle after each accepted write.
- **Throughput:** 1 beat per cycle with `tready`=1 and D=0; the FIFO never fills in that case.

## Test plan
- **Basic frame.** Set `FRAME_LEN`=8, D=0, `tready`=1, `data_i` = cycle counter. Raise `enable_i`. Expect:
  - 8 consecutive beats with consecutive values;
  - `tlast` on beat 8 only;
  - `finished_o`=1 one cycle after beat 8, `overflow_o`=0;
  - `finished_o` clears after `enable_i` drops.
- **Decimation.** Set D=3 with `data_i` = cycle counter. Expect beat values spaced by 4, first value = counter at edge N+1. A `decim_i` change mid-frame has no effect.
- **Backpressure overflow.** Set `FIFO_DEPTH`=4, `FRAME_LEN`=8, D=0. Hold `tready`=0 for 10 cycles after start, then release. Expect:
  - samples 1–4 kept;
  - next 6 strobes dropped, `overflow_o`=1;
  - 4 later samples accepted, 8 beats total;
  - a value gap between beats 4 and 5; `tlast` on beat 8.
- **Stall stability.** Randomise `tready`. Expect `tdata`/`tlast` constant while `tvalid`=1 and `tready`=0, and exactly 8 handshakes per frame.
- **Enable drop.** Deassert `enable_i` after 3 beats. Expect the frame to complete with 8 beats and `tlast`, `finished_o` pulse for 1 cycle, then IDLE.
- **Reset and no re-arm.**
  - Assert `rst_i` during DRAIN. Expect `tvalid`=0, counts 0 and IDLE immediately, and a fresh frame afterwards.
  - Hold `enable_i` high in DONE. Expect no second frame until `enable_i` toggles.
